// File: rtl/tl_stim_sequencer.sv
// tl_stim_sequencer: per-channel command FIFOs driving TileLink L1 request
// ports, with completion checking, timeouts and saturating pass/fail totals.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif

module tl_stim_sequencer #(
  parameter int NUM_L1     = 4,
  parameter int ADDR_W     = `TL_ADDR_BITS,
  parameter int SIZE_W     = `TL_SIZE_BITS,
  parameter int SRC_W      = `TL_SOURCE_BITS,
  parameter int DBYTES     = `TL_DATA_BYTES,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NUM_L1 > 1) ? $clog2(NUM_L1) : 1,
  localparam int DW        = 8 * DBYTES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       go,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CH_W-1:0]            cmd_chan,
  input  logic [1:0]                 cmd_type,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [SIZE_W-1:0]          cmd_size,
  input  logic [SRC_W-1:0]           cmd_source,
  input  logic [DW-1:0]              cmd_data,
  input  logic [DW-1:0]              cmd_expect,
  input  logic [DBYTES-1:0]          cmd_mask,
  input  logic                       cmd_check,
  output logic [NUM_L1-1:0]          start_transaction,
  output logic [2*NUM_L1-1:0]        transaction_type,
  output logic [NUM_L1*ADDR_W-1:0]   address,
  output logic [NUM_L1*SIZE_W-1:0]   size,
  output logic [NUM_L1*SRC_W-1:0]    source,
  output logic [NUM_L1*DW-1:0]       write_data,
  output logic [NUM_L1*DBYTES-1:0]   write_mask,
  input  logic [NUM_L1-1:0]          transaction_done,
  input  logic [NUM_L1*DW-1:0]       read_data,
  output logic                       busy,
  output logic [CNT_W-1:0]           pass_count,
  output logic [CNT_W-1:0]           fail_count,
  output logic [NUM_L1-1:0]          timeout_err,
  output logic                       test_done,
  output logic                       all_tests_passed
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IW = $clog2(NUM_L1 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } st_e;

  logic [NUM_L1-1:0] full;
  logic [NUM_L1-1:0] pass_ev;
  logic [NUM_L1-1:0] fail_ev;
  logic [NUM_L1-1:0] busy_ch;
  logic              chan_ok;

  assign chan_ok   = 32'(cmd_chan) < NUM_L1;
  assign cmd_ready = chan_ok && !full[cmd_chan];

  for (genvar g = 0; g < NUM_L1; g++) begin : g_ch
    logic [1:0]        m_type [FIFO_DEPTH];
    logic [ADDR_W-1:0] m_addr [FIFO_DEPTH];
    logic [SIZE_W-1:0] m_size [FIFO_DEPTH];
    logic [SRC_W-1:0]  m_src  [FIFO_DEPTH];
    logic [DW-1:0]     m_data [FIFO_DEPTH];
    logic [DW-1:0]     m_exp  [FIFO_DEPTH];
    logic [DBYTES-1:0] m_mask [FIFO_DEPTH];
    logic              m_chk  [FIFO_DEPTH];

    logic [AW:0]       wr_q, rd_q;
    logic [AW-1:0]     wa, ra;
    logic              empty, push, pop, load, to_set;
    st_e               st_q, st_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              to_q;
    logic [1:0]        p_type_q;
    logic [ADDR_W-1:0] p_addr_q;
    logic [SIZE_W-1:0] p_size_q;
    logic [SRC_W-1:0]  p_src_q;
    logic [DW-1:0]     p_data_q;
    logic [DW-1:0]     p_exp_q;
    logic [DBYTES-1:0] p_mask_q;
    logic              p_chk_q;
    logic [DW-1:0]     rdata;
    logic              mism;
    logic              head_rsv;

    assign wa       = wr_q[AW-1:0];
    assign ra       = rd_q[AW-1:0];
    assign empty    = wr_q == rd_q;
    assign full[g]  = (wr_q[AW] != rd_q[AW]) && (wa == ra);
    assign head_rsv = m_type[ra] == 2'd3;

    // A halted channel swallows new commands instead of queueing them
    assign push = cmd_valid && cmd_ready &&
                  (cmd_chan == CH_W'(g)) && (st_q != S_HALT);

    always_ff @(posedge clk) begin
      if (push) begin
        m_type[wa] <= cmd_type;
        m_addr[wa] <= cmd_addr;
        m_size[wa] <= cmd_size;
        m_src[wa]  <= cmd_source;
        m_data[wa] <= cmd_data;
        m_exp[wa]  <= cmd_expect;
        m_mask[wa] <= cmd_mask;
        m_chk[wa]  <= cmd_check;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end

    assign rdata = read_data[g*DW +: DW];
    assign mism  = (p_type_q == 2'd0) && p_chk_q && (rdata != p_exp_q);

    // Completion resolves in the done cycle so the next issue follows at once
    always_comb begin
      st_d       = st_q;
      tmr_d      = tmr_q;
      pop        = 1'b0;
      load       = 1'b0;
      to_set     = 1'b0;
      pass_ev[g] = 1'b0;
      fail_ev[g] = 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (go && !empty) begin
            pop = 1'b1;
            if (head_rsv) begin
              fail_ev[g] = 1'b1;
            end else begin
              load = 1'b1;
              st_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tmr_d = '0;
          st_d  = S_WAIT;
        end
        S_WAIT: begin
          if (transaction_done[g]) begin
            pass_ev[g] = !mism;
            fail_ev[g] = mism;
            tmr_d      = '0;
            if (go && !empty && !head_rsv) begin
              pop  = 1'b1;
              load = 1'b1;
              st_d = S_ISSUE;
            end else begin
              st_d = S_IDLE;
            end
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            fail_ev[g] = 1'b1;
            to_set     = 1'b1;
            st_d       = S_HALT;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_HALT: begin
          if (!empty) begin
            pop        = 1'b1;
            fail_ev[g] = 1'b1;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= S_IDLE;
        tmr_q <= '0;
        to_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        tmr_q <= tmr_d;
        if (to_set) to_q <= 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_type_q <= '0;
        p_addr_q <= '0;
        p_size_q <= '0;
        p_src_q  <= '0;
        p_data_q <= '0;
        p_exp_q  <= '0;
        p_mask_q <= '0;
        p_chk_q  <= 1'b0;
      end else if (load) begin
        p_type_q <= m_type[ra];
        p_addr_q <= m_addr[ra];
        p_size_q <= m_size[ra];
        p_src_q  <= m_src[ra];
        p_data_q <= m_data[ra];
        p_exp_q  <= m_exp[ra];
        p_mask_q <= m_mask[ra];
        p_chk_q  <= m_chk[ra];
      end
    end

    assign start_transaction[g]            = st_q == S_ISSUE;
    assign transaction_type[2*g +: 2]      = p_type_q;
    assign address[g*ADDR_W +: ADDR_W]     = p_addr_q;
    assign size[g*SIZE_W +: SIZE_W]        = p_size_q;
    assign source[g*SRC_W +: SRC_W]        = p_src_q;
    assign write_data[g*DW +: DW]          = p_data_q;
    assign write_mask[g*DBYTES +: DBYTES]  = p_mask_q;
    assign timeout_err[g]                  = to_q;
    assign busy_ch[g] = !empty || (st_q == S_ISSUE) || (st_q == S_WAIT);
  end

  logic [IW-1:0]    n_pass, n_fail;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic             res_q, done_q;
  logic             any_ev;

  always_comb begin
    n_pass = '0;
    n_fail = '0;
    for (int i = 0; i < NUM_L1; i++) begin
      n_pass = n_pass + IW'(pass_ev[i]);
      n_fail = n_fail + IW'(fail_ev[i]);
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [IW-1:0]    b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign busy   = |busy_ch;
  assign any_ev = |pass_ev || |fail_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      pass_q <= sat_add(pass_q, n_pass);
      fail_q <= sat_add(fail_q, n_fail);
    end
  end

  // Completion needs a resolved command since go rose, so an idle start
  // does not report done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (!go) begin
      res_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (any_ev) res_q <= 1'b1;
      if (!busy && res_q) done_q <= 1'b1;
    end
  end

  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign test_done        = done_q;
  assign all_tests_passed = done_q && (fail_q == '0) && (timeout_err == '0);

endmodule
